// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg -- shared types and default widths for the writeback stage.
//
// Contents:
//   WB_DATA_W / WB_REG_AW / WB_CNT_W : default datapath, register-index and
//                                      retire-counter widths
//   wb_src_e   : writeback source select (ALU, LOAD, LINK; code 2'b11 is
//                reserved and handled as ALU by the stage)
//   ld_size_e  : load access size (byte, half, word; code 2'b11 acts as word)
//   wb_state_e : writeback FSM states
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_REG_AW = 5;
  localparam int WB_CNT_W  = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10
  } wb_src_e;

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10
  } ld_size_e;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align -- combinational load-data lane select and extension.
//
// Ports:
//   rdata       in  DATA_W  raw word returned by the data memory
//   size        in  2       00 byte, 01 half, 10/11 word
//   ld_unsigned in  1       1 = zero-extend, 0 = sign-extend
//   offset      in  2       byte address bits [1:0] of the load
//   aligned     out DATA_W  value to write back
//
// Halfword loads use only offset[1]; a misaligned halfword rounds down to the
// containing aligned halfword. Word loads ignore the offset entirely.
// ---------------------------------------------------------------------------
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] aligned
);

  localparam int NB = DATA_W / 8;

  logic [7:0]  lanes [NB];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Split the word into byte lanes so offsets index lanes directly.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lanes[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_sel = lanes[offset];
    half_sel = {lanes[{offset[1], 1'b1}], lanes[{offset[1], 1'b0}]};
    aligned  = rdata;
    case (size)
      LD_B:    aligned = {{(DATA_W-8){~ld_unsigned & byte_sel[7]}}, byte_sel};
      LD_H:    aligned = {{(DATA_W-16){~ld_unsigned & half_sel[15]}}, half_sel};
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- writeback stage of the 5-stage core.
//
// Accepts retiring instructions from MEM over valid/ready, waits for load
// data where needed, aligns it, and drives the register-file write port from
// registers. Only one load may be outstanding; the stage drops in_ready while
// it waits, which costs one bubble per load.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             MEM handshake (in_ready = state is IDLE)
//   in_rd, in_wb_en, in_wb_src      destination, write enable, result source
//   in_alu_result, in_pc_plus4      ALU and link results
//   in_ld_size, in_ld_unsigned,
//   in_ld_offset                    load shape
//   mem_rvalid, mem_rdata           load data return (single-cycle pulse)
//   reg_wrt_en/sel/data             registered register-file write port
//   retire_cnt                      retired instruction count
//
// Build option: define WB_RETIRE_CNT_EN to include the retire counter;
// without it retire_cnt is tied to zero.
// ---------------------------------------------------------------------------
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = WB_REG_AW,
  parameter int CNT_W  = WB_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wb_en,
  input  logic [1:0]        in_wb_src,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_unsigned,
  input  logic [1:0]        in_ld_offset,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              reg_wrt_en,
  output logic [REG_AW-1:0] reg_wrt_sel,
  output logic [DATA_W-1:0] reg_wrt_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  wb_state_e state_reg, state_next;

  // Shape of the outstanding load, captured at accept.
  logic [REG_AW-1:0] ld_rd_reg, ld_rd_next;
  logic              ld_wb_en_reg, ld_wb_en_next;
  logic [1:0]        ld_size_reg, ld_size_next;
  logic              ld_unsigned_reg, ld_unsigned_next;
  logic [1:0]        ld_offset_reg, ld_offset_next;

  logic              wrt_en_reg, wrt_en_next;
  logic [REG_AW-1:0] wrt_sel_reg, wrt_sel_next;
  logic [DATA_W-1:0] wrt_data_reg, wrt_data_next;

  logic [DATA_W-1:0] aligned_data;

  load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .rdata       (mem_rdata),
    .size        (ld_size_reg),
    .ld_unsigned (ld_unsigned_reg),
    .offset      (ld_offset_reg),
    .aligned     (aligned_data)
  );

  assign in_ready = (state_reg == IDLE);

  always_comb begin
    state_next       = state_reg;
    ld_rd_next       = ld_rd_reg;
    ld_wb_en_next    = ld_wb_en_reg;
    ld_size_next     = ld_size_reg;
    ld_unsigned_next = ld_unsigned_reg;
    ld_offset_next   = ld_offset_reg;
    wrt_en_next      = 1'b0;
    // sel/data hold their last value unless a real write is scheduled.
    wrt_sel_next     = wrt_sel_reg;
    wrt_data_next    = wrt_data_reg;

    case (state_reg)
      IDLE: begin
        // mem_rvalid is deliberately not looked at here: spurious or
        // accept-cycle pulses must not complete anything.
        if (in_valid) begin
          if (in_wb_src == WB_LOAD) begin
            ld_rd_next       = in_rd;
            ld_wb_en_next    = in_wb_en;
            ld_size_next     = in_ld_size;
            ld_unsigned_next = in_ld_unsigned;
            ld_offset_next   = in_ld_offset;
            state_next       = WAIT_LD;
          end else if (in_wb_en && (in_rd != '0)) begin
            wrt_en_next   = 1'b1;
            wrt_sel_next  = in_rd;
            // Reserved source code falls through to the ALU result.
            wrt_data_next = (in_wb_src == WB_LINK) ? in_pc_plus4 : in_alu_result;
          end
        end
      end
      WAIT_LD: begin
        if (mem_rvalid) begin
          state_next = IDLE;
          if (ld_wb_en_reg && (ld_rd_reg != '0)) begin
            wrt_en_next   = 1'b1;
            wrt_sel_next  = ld_rd_reg;
            wrt_data_next = aligned_data;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ld_rd_reg       <= '0;
      ld_wb_en_reg    <= 1'b0;
      ld_size_reg     <= '0;
      ld_unsigned_reg <= 1'b0;
      ld_offset_reg   <= '0;
      wrt_en_reg      <= 1'b0;
      wrt_sel_reg     <= '0;
      wrt_data_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      ld_rd_reg       <= ld_rd_next;
      ld_wb_en_reg    <= ld_wb_en_next;
      ld_size_reg     <= ld_size_next;
      ld_unsigned_reg <= ld_unsigned_next;
      ld_offset_reg   <= ld_offset_next;
      wrt_en_reg      <= wrt_en_next;
      wrt_sel_reg     <= wrt_sel_next;
      wrt_data_reg    <= wrt_data_next;
    end
  end

  assign reg_wrt_en   = wrt_en_reg;
  assign reg_wrt_sel  = wrt_sel_reg;
  assign reg_wrt_data = wrt_data_reg;

`ifdef WB_RETIRE_CNT_EN
  // An instruction retires on the same edge that loads the write registers,
  // whether or not the write itself is suppressed by rd==0 / wb_en==0.
  logic             retire;
  logic [CNT_W-1:0] retire_cnt_reg;

  assign retire = ((state_reg == IDLE) && in_valid && (in_wb_src != WB_LOAD)) ||
                  ((state_reg == WAIT_LD) && mem_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_reg <= '0;
    end else if (retire) begin
      retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
    end
  end

  assign retire_cnt = retire_cnt_reg;
`else
  assign retire_cnt = '0;
`endif

endmodule
